// File: rtl/array_index_scheduler.sv
// rtl/array_index_scheduler.sv - round-robin request scheduler with indexed result table (ARRAY_INDEX_SCHED_ERR_CNT_EN enables the out-of-range read counter)
module array_index_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(NUM_REQ)-1:0]  out_index,
    input  logic [7:0]                  rd_index,
    output logic [DATA_W-1:0]           rd_data,
    output logic [7:0]                  err_cnt
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       rr_ptr;
    logic [NUM_REQ-1:0]     grant_q;
    logic [DATA_W-1:0]      table_q [NUM_REQ];

    logic                   sel_found;
    logic [IDX_W-1:0]       sel_idx;
    logic [IDX_W:0]         cand;
    logic [DATA_W-1:0]      sel_sum;
    logic                   do_select;
    logic                   do_accept;
    logic                   rd_oor;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        sel_found = |req;
        sel_idx   = '0;
        cand      = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (req[cand]) begin
                sel_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign sel_sum   = req_data[sel_idx*DATA_W +: DATA_W] + DATA_W'(sel_idx);
    assign do_select = (state == IDLE) && sel_found;
    assign do_accept = (state == HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sel_found) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == HOLD);
        grant     = grant_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_q   <= '0;
            out_data  <= '0;
            out_index <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            grant_q <= '0;
            if (do_select) begin
                grant_q[sel_idx]  <= 1'b1;
                out_data          <= sel_sum;
                out_index         <= sel_idx;
                table_q[sel_idx]  <= sel_sum;
            end
            if (do_accept) begin
                rr_ptr <= (out_index == IDX_W'(NUM_REQ - 1)) ? '0 : out_index + 1'b1;
            end
        end
    end

    assign rd_oor  = (rd_index >= 8'(NUM_REQ));
    assign rd_data = rd_oor ? '0 : table_q[rd_index[IDX_W-1:0]];

`ifdef ARRAY_INDEX_SCHED_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (rd_oor && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule
